control_sequencer: RTL and testbench

Microprogram sequencer for the SAP-BR 8-bit datapath. It runs a six-state one-hot ring counter that spans the shared fetch cycle (T1–T3) and the execute cycle (T4–T6). During execute it decodes the 4-bit opcode that the instruction register drives on its always-on low bus. From the state and opcode it produces every load, enable and ALU control line for the PC, MAR, RAM, IR, A, B, ALU and output register. It also owns the halt condition.

---
 rtl/control_sequencer_if.sv | 30 +++
 rtl/control_sequencer.sv | 168 ++++++++++++++++
 tb/tb_control_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Opcode/control bundle between the SAP-BR sequencer (master) and the datapath (slave).
interface control_sequencer_if;
  logic [3:0] OPCODE;
  logic       INC_PC;
  logic       EN_PC_OUT;
  logic       _EN_MAR_IN;
  logic       _EN_RAM_OUT;
  logic       _EN_IR_IN;
  logic       _EN_IR_OUT;
  logic       _EN_A_IN;
  logic       EN_A_OUT;
  logic       _EN_B_IN;
  logic       SUB;
  logic       EN_ALU_OUT;
  logic       _EN_OUT_IN;
  logic       HALT;
  logic [5:0] T_STATE;

  modport master (
    input  OPCODE,
    output INC_PC, EN_PC_OUT, _EN_MAR_IN, _EN_RAM_OUT, _EN_IR_IN, _EN_IR_OUT,
           _EN_A_IN, EN_A_OUT, _EN_B_IN, SUB, EN_ALU_OUT, _EN_OUT_IN, HALT, T_STATE
  );

  modport slave (
    output OPCODE,
    input  INC_PC, EN_PC_OUT, _EN_MAR_IN, _EN_RAM_OUT, _EN_IR_IN, _EN_IR_OUT,
           _EN_A_IN, EN_A_OUT, _EN_B_IN, SUB, EN_ALU_OUT, _EN_OUT_IN, HALT, T_STATE
  );
endinterface

// File: rtl/control_sequencer.sv
// SAP-BR six-state ring sequencer: fetch T1-T3, opcode-decoded execute T4-T6, sticky halt.
// Define CTRL_EARLY_RETIRE_EN to skip idle execute states (LDA 5 cycles, OUT/NOP 4 cycles).
module control_sequencer (
  input  logic                       CLOCK,
  input  logic                       RESET,
  control_sequencer_if.master        bus
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control vector indices; every line is computed active-high and re-polarised at the pins.
  localparam int C_INC_PC   = 0;
  localparam int C_PC_OUT   = 1;
  localparam int C_MAR_IN   = 2;
  localparam int C_RAM_OUT  = 3;
  localparam int C_IR_IN    = 4;
  localparam int C_IR_OUT   = 5;
  localparam int C_A_IN     = 6;
  localparam int C_A_OUT    = 7;
  localparam int C_B_IN     = 8;
  localparam int C_SUB      = 9;
  localparam int C_ALU_OUT  = 10;
  localparam int C_OUT_IN   = 11;
  localparam int NUM_CTRL   = 12;

  localparam logic [NUM_CTRL-1:0] ACT_LOW = 12'h97C;

  t_state_e              state_reg, state_next;
  logic                  halted_reg, halted_next;
  logic                  halt_active;
  logic                  ctrl_en;
  logic                  is_lda, is_add, is_sub, is_out, is_hlt, is_arith;
  logic [NUM_CTRL-1:0]   ctrl_act;
  logic [NUM_CTRL-1:0]   ctrl_pin;

  assign is_lda   = (bus.OPCODE == OP_LDA);
  assign is_add   = (bus.OPCODE == OP_ADD);
  assign is_sub   = (bus.OPCODE == OP_SUB);
  assign is_out   = (bus.OPCODE == OP_OUT);
  assign is_hlt   = (bus.OPCODE == OP_HLT);
  assign is_arith = is_add | is_sub;

`ifdef CTRL_EARLY_RETIRE_EN
  logic retire_t4, retire_t5;
  assign retire_t4 = ~(is_lda | is_arith | is_hlt);
  assign retire_t5 = is_lda;
`endif

  // Halt is visible combinationally on entering T4 and held afterwards by halted_reg.
  assign halt_active = halted_reg | ((state_reg == T4) & is_hlt);
  assign ctrl_en     = ~RESET & ~halt_active;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_reg  <= T1;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      halted_reg <= halted_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    halted_next = halt_active;
    case (state_reg)
      T1: state_next = T2;
      T2: state_next = T3;
      T3: state_next = T4;
      T4: begin
        if (halt_active) begin
          state_next = T4;
`ifdef CTRL_EARLY_RETIRE_EN
        end else if (retire_t4) begin
          state_next = T1;
`endif
        end else begin
          state_next = T5;
        end
      end
      T5: begin
`ifdef CTRL_EARLY_RETIRE_EN
        if (retire_t5) state_next = T1;
        else           state_next = T6;
`else
        state_next = T6;
`endif
      end
      T6:      state_next = T1;
      default: state_next = T1;
    endcase
  end

  always_comb begin
    ctrl_act = '0;
    case (state_reg)
      T1: begin
        ctrl_act[C_PC_OUT] = 1'b1;
        ctrl_act[C_MAR_IN] = 1'b1;
      end
      T2: ctrl_act[C_INC_PC] = 1'b1;
      T3: begin
        ctrl_act[C_RAM_OUT] = 1'b1;
        ctrl_act[C_IR_IN]   = 1'b1;
      end
      T4: begin
        if (is_lda | is_arith) begin
          ctrl_act[C_IR_OUT] = 1'b1;
          ctrl_act[C_MAR_IN] = 1'b1;
        end else if (is_out) begin
          ctrl_act[C_A_OUT]  = 1'b1;
          ctrl_act[C_OUT_IN] = 1'b1;
        end
      end
      T5: begin
        if (is_lda) begin
          ctrl_act[C_RAM_OUT] = 1'b1;
          ctrl_act[C_A_IN]    = 1'b1;
        end else if (is_arith) begin
          ctrl_act[C_RAM_OUT] = 1'b1;
          ctrl_act[C_B_IN]    = 1'b1;
          ctrl_act[C_SUB]     = is_sub;
        end
      end
      T6: begin
        if (is_arith) begin
          ctrl_act[C_ALU_OUT] = 1'b1;
          ctrl_act[C_A_IN]    = 1'b1;
          ctrl_act[C_SUB]     = is_sub;
        end
      end
      default: ctrl_act = '0;
    endcase
  end

  for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_pin
    assign ctrl_pin[gi] = (ctrl_act[gi] & ctrl_en) ^ ACT_LOW[gi];
  end

  assign bus.INC_PC      = ctrl_pin[C_INC_PC];
  assign bus.EN_PC_OUT   = ctrl_pin[C_PC_OUT];
  assign bus._EN_MAR_IN  = ctrl_pin[C_MAR_IN];
  assign bus._EN_RAM_OUT = ctrl_pin[C_RAM_OUT];
  assign bus._EN_IR_IN   = ctrl_pin[C_IR_IN];
  assign bus._EN_IR_OUT  = ctrl_pin[C_IR_OUT];
  assign bus._EN_A_IN    = ctrl_pin[C_A_IN];
  assign bus.EN_A_OUT    = ctrl_pin[C_A_OUT];
  assign bus._EN_B_IN    = ctrl_pin[C_B_IN];
  assign bus.SUB         = ctrl_pin[C_SUB];
  assign bus.EN_ALU_OUT  = ctrl_pin[C_ALU_OUT];
  assign bus._EN_OUT_IN  = ctrl_pin[C_OUT_IN];
  assign bus.HALT        = halt_active & ~RESET;
  assign bus.T_STATE     = state_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a per-opcode micro-op table predicts every cycle.
module tb_control_sequencer;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  control_sequencer_if bus();

  control_sequencer dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic inc_pc, en_pc_out, n_mar_in, n_ram_out, n_ir_in, n_ir_out;
    logic n_a_in, en_a_out, n_b_in, sub, en_alu_out, n_out_in;
  } pins_t;

  typedef struct {
    pins_t      pins;
    logic [5:0] t_state;
    logic       halt;
    logic [3:0] op;
    int         step;
  } exp_t;

  localparam pins_t IDLE = '{inc_pc:1'b0, en_pc_out:1'b0, n_mar_in:1'b1, n_ram_out:1'b1,
                             n_ir_in:1'b1, n_ir_out:1'b1, n_a_in:1'b1, en_a_out:1'b0,
                             n_b_in:1'b1, sub:1'b0, en_alu_out:1'b0, n_out_in:1'b1};

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;
  bit   stop = 1'b0;

  function automatic bit is_nop(input logic [3:0] op);
    return !(op inside {4'h0, 4'h1, 4'h2, 4'hE, 4'hF});
  endfunction

  // Cycles from T1 back to T1 for one instruction.
  function automatic int inst_len(input logic [3:0] op);
`ifdef CTRL_EARLY_RETIRE_EN
    if (op == 4'h0) return 5;
    if (op == 4'hE || is_nop(op)) return 4;
    return 6;
`else
    return (op == 4'hF) ? 4 : 6;
`endif
  endfunction

  function automatic exp_t model(input logic [3:0] op, input int step);
    exp_t e;
    e.pins = IDLE; e.t_state = 6'b000001 << step; e.halt = 1'b0; e.op = op; e.step = step;
    case (step)
      0: begin e.pins.en_pc_out = 1'b1; e.pins.n_mar_in = 1'b0; end
      1: e.pins.inc_pc = 1'b1;
      2: begin e.pins.n_ram_out = 1'b0; e.pins.n_ir_in = 1'b0; end
      default: begin
        if (op == 4'hF) begin
          e.halt = 1'b1; e.t_state = 6'b001000;
        end else if (op == 4'hE) begin
          if (step == 3) begin e.pins.en_a_out = 1'b1; e.pins.n_out_in = 1'b0; end
        end else if (op == 4'h0) begin
          if (step == 3) begin e.pins.n_ir_out = 1'b0; e.pins.n_mar_in = 1'b0; end
          if (step == 4) begin e.pins.n_ram_out = 1'b0; e.pins.n_a_in = 1'b0; end
        end else if (op == 4'h1 || op == 4'h2) begin
          if (step == 3) begin e.pins.n_ir_out = 1'b0; e.pins.n_mar_in = 1'b0; end
          if (step == 4) begin e.pins.n_ram_out = 1'b0; e.pins.n_b_in = 1'b0; end
          if (step == 5) begin e.pins.en_alu_out = 1'b1; e.pins.n_a_in = 1'b0; end
          if (step >= 4) e.pins.sub = (op == 4'h2);
        end
      end
    endcase
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.pins = IDLE; e.t_state = 6'b000001; e.halt = 1'b0; e.op = 4'h0; e.step = -1;
    return e;
  endfunction

  task automatic step_cycle(input logic [3:0] drive_op, input exp_t e);
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    bus.OPCODE = drive_op;
    sb.push_back(e);
  endtask

  // Asynchronous reset pulse held across the sampling edge, released before the next rising edge.
  task automatic reset_pulse();
    @(posedge CLOCK); #2;
    RESET = 1'b1;
    bus.OPCODE = 4'($urandom_range(0, 15));
    sb.push_back(reset_exp());
    @(negedge CLOCK); #1;
    RESET = 1'b0;
  endtask

  // Runs one instruction from first_step; opcode is junk during fetch. Returns the next first step.
  task automatic run_inst(input logic [3:0] op, input int first_step, input int abort_at,
                          output int next_first);
    next_first = 0;
    for (int k = first_step; k < inst_len(op); k++) begin
      if (k == abort_at) begin
        reset_pulse();
        next_first = 1;
        return;
      end
      step_cycle((k < 3) ? 4'($urandom_range(0, 15)) : op, model(op, k));
    end
  endtask

  initial begin
    int nf;
    int ab;
    logic [3:0] op;
    logic [3:0] directed [5] = '{4'h0, 4'h1, 4'h2, 4'hE, 4'h7};
    bus.OPCODE = 4'h0;
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLOCK); #1;
      sb.push_back(reset_exp());
    end
    nf = 0;
    foreach (directed[i]) run_inst(directed[i], nf, -1, nf);
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 14));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_inst(op, nf, ab, nf);
    end
    run_inst(4'hF, nf, -1, nf);
    for (int i = 0; i < 20; i++) step_cycle(4'hF, model(4'hF, 3));
    reset_pulse();
    run_inst(4'h0, 1, -1, nf);
    run_inst(4'h2, nf, -1, nf);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge CLOCK);
    #1 stop = 1'b1;
  end

  always @(negedge CLOCK) begin
    exp_t  e;
    pins_t a;
    int    drivers;
    if (stop) begin
      total++;
      if (sb.size() == 0) passed++;
      else $display("FAIL drain: actual %0d pending expectations, required 0", sb.size());
      $display("%0d/%0d checks passed", passed, total);
      $finish;
    end else begin
      a = {bus.INC_PC, bus.EN_PC_OUT, bus._EN_MAR_IN, bus._EN_RAM_OUT, bus._EN_IR_IN,
           bus._EN_IR_OUT, bus._EN_A_IN, bus.EN_A_OUT, bus._EN_B_IN, bus.SUB,
           bus.EN_ALU_OUT, bus._EN_OUT_IN};
      drivers = int'(a.en_pc_out) + int'(!a.n_ram_out) + int'(!a.n_ir_out)
              + int'(a.en_a_out) + int'(a.en_alu_out);
      total++;
      if (drivers <= 1) passed++;
      else $display("FAIL bus_excl @%0t: actual %0d bus drivers, required <=1", $time, drivers);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        total++;
        if (bus.T_STATE === e.t_state) passed++;
        else $display("FAIL t_state op=%h step=%0d: actual %b required %b",
                      e.op, e.step, bus.T_STATE, e.t_state);
        total++;
        if (bus.HALT === e.halt) passed++;
        else $display("FAIL halt op=%h step=%0d: actual %b required %b",
                      e.op, e.step, bus.HALT, e.halt);
        total++;
        if (a === e.pins) passed++;
        else $display("FAIL ctrl op=%h step=%0d: actual %b required %b",
                      e.op, e.step, a, e.pins);
      end
    end
  end

endmodule
